// File: rtl/torpedo_launch_sched.sv
// torpedo_launch_sched: round-robin torpedo launch sequencer.
// A fire request claims a free torpedo slot, reads the shared sin/cos ROM
// once, then emits a one-hot launch pulse with the captured ship position
// and heading, followed by a vsync-counted cooldown.
// Optional feature: define AUTOFIRE_EN to let vsync act as a request while
// fire is held in IDLE (one launch per cooldown period).
module torpedo_launch_sched #(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int SLOTS           = 4,
    parameter int TRIG_LAT        = 2,
    parameter int COOLDOWN_FRAMES = 3,
    localparam int X_W            = $clog2(WIDTH),
    localparam int Y_W            = $clog2(HEIGHT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vsync,
    input  logic                    fire,
    input  logic [X_W-1:0]          ship_x,
    input  logic [Y_W-1:0]          ship_y,
    input  logic [8:0]              ship_angle,
    input  logic [SLOTS-1:0]        slot_busy,
    output logic                    trig_req,
    output logic [8:0]              trig_angle,
    input  logic signed [17:0]      sin_val,
    input  logic signed [17:0]      cos_val,
    output logic [SLOTS-1:0]        launch,
    output logic [X_W-1:0]          launch_x,
    output logic [Y_W-1:0]          launch_y,
    output logic signed [17:0]      launch_sin,
    output logic signed [17:0]      launch_cos,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    localparam int SW    = $clog2(SLOTS);
    localparam int LAT_W = (TRIG_LAT > 1) ? $clog2(TRIG_LAT) : 1;
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TRIG   = 3'd1,
        WAIT   = 3'd2,
        LAUNCH = 3'd3,
        COOL   = 3'd4
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              fire_d;
    logic [LAT_W-1:0]  lat_cnt;
    logic [CD_W-1:0]   cooldown;
    logic [SW-1:0]     last;
    logic [SW-1:0]     slot;
    logic [X_W-1:0]    cap_x;
    logic [Y_W-1:0]    cap_y;
    logic [8:0]        cap_angle;
    logic              request;
    logic              accept;
    logic              no_free;
    logic              lat_done;
    logic [SW:0]       pick;

    // Saturating increment for the refused-request counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Round-robin search: first free slot after 'prev', wrapping; MSB = found.
    function automatic logic [SW:0] pick_slot(input logic [SLOTS-1:0] sb,
                                              input logic [SW-1:0]    prev);
        logic [SW:0] res;
        int          idx;
        res = '0;
        // Scan farthest offset first so the nearest free slot wins.
        for (int i = SLOTS; i >= 1; i--) begin
            idx = (int'(prev) + i) % SLOTS;
            if (!sb[idx]) res = {1'b1, SW'(idx)};
        end
        return res;
    endfunction

    // Request decode: rising fire edge, plus held-fire vsync in autofire builds.
    always_comb begin
`ifdef AUTOFIRE_EN
        request = (fire & ~fire_d) | (vsync & fire);
`else
        request = fire & ~fire_d;
`endif
        accept   = (state == IDLE) && (cooldown == '0) && request;
        no_free  = &slot_busy;
        lat_done = (lat_cnt == LAT_W'(TRIG_LAT - 1));
        pick     = pick_slot(slot_busy, last);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !no_free) next_state = TRIG;
            TRIG:    next_state = WAIT;
            WAIT:    if (lat_done) next_state = LAUNCH;
            LAUNCH:  next_state = (COOLDOWN_FRAMES == 0) ? IDLE : COOL;
            COOL:    if (cooldown == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears pulses immediately.
    always_comb begin
        trig_req   = (state == TRIG);
        trig_angle = (state == TRIG) ? cap_angle : 9'd0;
        launch     = (state == LAUNCH) ? (SLOTS'(1) << slot) : '0;
        busy       = (state != IDLE);
    end

    // Control counters, slot bookkeeping and the launch output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_d     <= 1'b0;
            lat_cnt    <= '0;
            cooldown   <= '0;
            last       <= SW'(SLOTS - 1);
            slot       <= '0;
            drop_cnt   <= 8'd0;
            launch_x   <= '0;
            launch_y   <= '0;
            launch_sin <= '0;
            launch_cos <= '0;
        end else begin
            fire_d <= fire;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (no_free) drop_cnt <= sat_inc8(drop_cnt);
                        else         slot     <= pick[SW-1:0];
                    end
                end
                TRIG: lat_cnt <= '0;
                WAIT: begin
                    lat_cnt <= lat_cnt + LAT_W'(1);
                    // ROM data is valid in the final wait cycle.
                    if (lat_done) begin
                        launch_x   <= cap_x;
                        launch_y   <= cap_y;
                        launch_sin <= sin_val;
                        launch_cos <= cos_val;
                    end
                end
                LAUNCH: begin
                    last     <= slot;
                    cooldown <= CD_W'(COOLDOWN_FRAMES);
                end
                COOL: if (vsync && cooldown != '0) cooldown <= cooldown - CD_W'(1);
                default: ;
            endcase
        end
    end

    // Ship state snapshot taken when a request is accepted.
    always_ff @(posedge clk) begin
        if (accept && !no_free) begin
            cap_x     <= ship_x;
            cap_y     <= ship_y;
            cap_angle <= ship_angle;
        end
    end

endmodule

// File: tb/tb_torpedo_launch_sched.sv
// tb_torpedo_launch_sched: directed scenarios plus randomized traffic for
// torpedo_launch_sched, checked cycle by cycle against a timeline model.
module tb_torpedo_launch_sched;

    localparam int SLOTS = 4;
    localparam int LAT   = 2;
    localparam int CD    = 3;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   vsync = 1'b0;
    logic                   fire = 1'b0;
    logic [X_W-1:0]         ship_x = '0;
    logic [Y_W-1:0]         ship_y = '0;
    logic [8:0]             ship_angle = '0;
    logic [SLOTS-1:0]       slot_busy = '0;
    logic                   trig_req;
    logic [8:0]             trig_angle;
    logic signed [17:0]     sin_val = '0;
    logic signed [17:0]     cos_val = '0;
    logic [SLOTS-1:0]       launch;
    logic [X_W-1:0]         launch_x;
    logic [Y_W-1:0]         launch_y;
    logic signed [17:0]     launch_sin;
    logic signed [17:0]     launch_cos;
    logic                   busy;
    logic [7:0]             drop_cnt;

    torpedo_launch_sched #(
        .WIDTH(640), .HEIGHT(480), .SLOTS(SLOTS),
        .TRIG_LAT(LAT), .COOLDOWN_FRAMES(CD)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .fire(fire),
        .ship_x(ship_x), .ship_y(ship_y), .ship_angle(ship_angle),
        .slot_busy(slot_busy), .trig_req(trig_req), .trig_angle(trig_angle),
        .sin_val(sin_val), .cos_val(cos_val), .launch(launch),
        .launch_x(launch_x), .launch_y(launch_y),
        .launch_sin(launch_sin), .launch_cos(launch_cos),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_launch = 0;
    logic [SLOTS-1:0] seen_launch = '0;
    int vph = 0;

    // Reference model: a sequence is a timeline anchored at its accept cycle.
    int                 m_c = 0;
    int                 m_t0 = 0;
    bit                 m_active = 0;
    int                 m_slot = 0;
    int                 m_last = SLOTS - 1;
    int                 m_vs = 0;
    int                 m_drop = 0;
    bit                 m_fprev = 0;
    logic [X_W-1:0]     m_cx, m_lx;
    logic [Y_W-1:0]     m_cy, m_ly;
    logic [8:0]         m_ca;
    logic signed [17:0] m_ls, m_lc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_last   = SLOTS - 1;
        m_drop   = 0;
        m_fprev  = 0;
        m_lx = '0; m_ly = '0; m_ls = '0; m_lc = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input logic f, input logic v, input logic [SLOTS-1:0] sb, input logic r);
        int               k;
        bit               req;
        bit               found;
        int               idx;
        logic [SLOTS-1:0] exp_launch;
        @(posedge clk);
        #1;
        reset      = r;
        fire       = f;
        vsync      = v;
        slot_busy  = sb;
        ship_x     = X_W'($urandom_range(639));
        ship_y     = Y_W'($urandom_range(479));
        ship_angle = 9'($urandom_range(359));
        sin_val    = 18'($urandom);
        cos_val    = 18'($urandom);
        if (r) model_reset();
        @(negedge clk);
        k = m_c - m_t0;
        exp_launch = (m_active && k == LAT + 2) ? SLOTS'(1 << m_slot) : '0;
        chk("busy",     32'(busy),     32'(m_active));
        chk("trig_req", 32'(trig_req), 32'(m_active && k == 1));
        if (m_active && k == 1) chk("trig_angle", 32'(trig_angle), 32'(m_ca));
        chk("launch",     32'(launch),     32'(exp_launch));
        chk("launch_x",   32'(launch_x),   32'(m_lx));
        chk("launch_y",   32'(launch_y),   32'(m_ly));
        chk("launch_sin", 32'(launch_sin), 32'(m_ls));
        chk("launch_cos", 32'(launch_cos), 32'(m_lc));
        chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
        if (launch != '0) begin
            n_launch++;
            seen_launch = launch;
        end
        if (!r) begin
            if (m_active) begin
                if (k == LAT + 1) begin
                    m_lx = m_cx; m_ly = m_cy; m_ls = sin_val; m_lc = cos_val;
                end
                if (k == LAT + 2) begin
                    m_last = m_slot;
                    m_vs   = CD;
                    if (m_vs == 0) m_active = 0;
                end else if (k > LAT + 2) begin
                    if (m_vs == 0) m_active = 0;
                    else if (v) m_vs--;
                end
            end else begin
                req = f && !m_fprev;
`ifdef AUTOFIRE_EN
                if (v && f) req = 1;
`endif
                if (req) begin
                    if (&sb) begin
                        if (m_drop < 255) m_drop++;
                    end else begin
                        found = 0;
                        for (int i = 1; i <= SLOTS; i++) begin
                            idx = (m_last + i) % SLOTS;
                            if (!found && !sb[idx]) begin
                                found  = 1;
                                m_slot = idx;
                            end
                        end
                        m_cx = ship_x; m_cy = ship_y; m_ca = ship_angle;
                        m_t0 = m_c;
                        m_active = 1;
                    end
                end
            end
        end
        m_fprev = r ? 1'b0 : f;
        m_c++;
    endtask

    // n cycles with a fixed fire level and slot mask; vsync every 6 cycles.
    task automatic run(input int n, input logic f, input logic [SLOTS-1:0] sb);
        for (int i = 0; i < n; i++) begin
            cyc(f, (vph == 0), sb, 1'b0);
            vph = (vph + 1) % 6;
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        logic f;
        logic [SLOTS-1:0] sb;
        model_reset();

        // Reset state, then first fire edge at cycle 10 with all slots free.
        do_reset(3);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_drop",   32'(drop_cnt), 32'd0);
        chk("rst_launch", 32'(launch),   32'd0);
        run(7, 1'b0, '0);
        run(1, 1'b1, '0);
        run(4, 1'b1, '0);
        chk("first_slot",  32'(seen_launch), 32'b0001);
        chk("first_count", 32'(n_launch),    32'd1);
        run(40, 1'b1, '0);
`ifndef AUTOFIRE_EN
        chk("held_no_repeat", 32'(n_launch), 32'd1);
`endif
        run(30, 1'b0, '0);

        // Round-robin around busy slots.
        do_reset(2);
        run(3, 1'b0, '0);
        run(1, 1'b1, 4'b0011);
        run(6, 1'b0, 4'b0011);
        chk("rr_slot2", 32'(seen_launch), 32'b0100);
        run(40, 1'b0, '0);
        run(1, 1'b1, 4'b0111);
        run(6, 1'b0, 4'b0111);
        chk("rr_slot3", 32'(seen_launch), 32'b1000);
        run(40, 1'b0, '0);

        // All slots busy: three refused requests.
        do_reset(2);
        run(3, 1'b0, '0);
        n0 = n_launch;
        for (int i = 0; i < 3; i++) begin
            run(1, 1'b1, 4'b1111);
            run(2, 1'b0, 4'b1111);
        end
        chk("drop3",        32'(drop_cnt), 32'd3);
        chk("drop_nolaunch", 32'(n_launch), 32'(n0));

        // Fire edge during cooldown is ignored.
        do_reset(2);
        run(3, 1'b0, '0);
        n0 = n_launch;
        run(1, 1'b1, '0);
        run(5, 1'b0, '0);
        chk("cool_first", 32'(n_launch), 32'(n0 + 1));
        run(8, 1'b0, '0);
        run(1, 1'b1, '0);
        run(3, 1'b0, '0);
        chk("cool_ignored", 32'(n_launch), 32'(n0 + 1));
        run(30, 1'b0, '0);
        run(1, 1'b1, '0);
        run(5, 1'b0, '0);
        chk("cool_after", 32'(n_launch), 32'(n0 + 2));

        // Reset while waiting for ROM data.
        do_reset(2);
        run(3, 1'b0, '0);
        n0 = n_launch;
        run(3, 1'b1, '0);
        cyc(1'b1, 1'b0, '0, 1'b1);
        chk("rst_wait_busy",   32'(busy),     32'd0);
        chk("rst_wait_launch", 32'(launch),   32'd0);
        chk("rst_wait_drop",   32'(drop_cnt), 32'd0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        run(3, 1'b0, '0);
        chk("rst_wait_none", 32'(n_launch), 32'(n0));
        run(1, 1'b1, '0);
        run(5, 1'b0, '0);
        chk("rst_wait_slot0", 32'(seen_launch), 32'b0001);

`ifdef AUTOFIRE_EN
        // Fire held for 12 frames.
        do_reset(2);
        run(3, 1'b0, '0);
        run(72, 1'b1, '0);
        run(30, 1'b0, '0);
`endif

        // Randomized traffic.
        f = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) f = ~f;
            sb = ($urandom_range(3) == 0) ? 4'hF : SLOTS'($urandom);
            cyc(f, ($urandom_range(7) == 0), sb, ($urandom_range(599) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
